traffic_controller: RTL

TRAFFIC_CONTROLLER -- requirements
Module: traffic_controller

---
 rtl/traffic_controller_if.sv | 25 ++
 rtl/traffic_controller.sv | 112 +++++++++++
 2 files changed

// File: rtl/traffic_controller_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// traffic_controller_if : sensor/time-base inputs and lamp outputs of the
//                         intersection controller.   Rev 1.0
// ---------------------------------------------------------------------------
interface traffic_controller_if;
   logic       tick;
   logic       ped_req;
   logic       ew_sensor;
   logic [2:0] ns_lamp;
   logic [2:0] ew_lamp;
   logic       walk;
   logic [2:0] phase;

   modport master (
      output tick, ped_req, ew_sensor,
      input  ns_lamp, ew_lamp, walk, phase
   );

   modport slave (
      input  tick, ped_req, ew_sensor,
      output ns_lamp, ew_lamp, walk, phase
   );
endinterface
`default_nettype wire

// File: rtl/traffic_controller.sv
`default_nettype none
// ---------------------------------------------------------------------------
// traffic_controller : two-road intersection sequencer with pedestrian walk
//                      phase and east-west demand detection.   Rev 1.0
// ---------------------------------------------------------------------------
module traffic_controller #(
   parameter int GREEN_TICKS  = 30,
   parameter int YELLOW_TICKS = 4,
   parameter int ALLRED_TICKS = 2,
   parameter int WALK_TICKS   = 10
) (
   input  wire logic            clkin,
   input  wire logic            rst_n,
   traffic_controller_if.slave  bus
);

   localparam logic [2:0] S_NS_GREEN  = 3'd0;
   localparam logic [2:0] S_NS_YELLOW = 3'd1;
   localparam logic [2:0] S_RED1      = 3'd2;
   localparam logic [2:0] S_WALK      = 3'd3;
   localparam logic [2:0] S_EW_GREEN  = 3'd4;
   localparam logic [2:0] S_EW_YELLOW = 3'd5;
   localparam logic [2:0] S_RED2      = 3'd6;

   localparam logic [7:0] C_GREEN_M1  = 8'(GREEN_TICKS - 1);
   localparam logic [7:0] C_YELLOW_M1 = 8'(YELLOW_TICKS - 1);
   localparam logic [7:0] C_ALLRED_M1 = 8'(ALLRED_TICKS - 1);
   localparam logic [7:0] C_WALK_M1   = 8'(WALK_TICKS - 1);

   localparam logic [2:0] C_RED    = 3'b100;
   localparam logic [2:0] C_YELLOW = 3'b010;
   localparam logic [2:0] C_GREEN  = 3'b001;

   logic [2:0] state_q, state_d;
   logic [7:0] timer_q, timer_d;
   logic       ped_pending_q, ped_pending_d;
   logic       car_pending_q, car_pending_d;

   function automatic logic [7:0] load_value(input logic [2:0] s);
      case (s)
         S_NS_GREEN, S_EW_GREEN:   load_value = C_GREEN_M1;
         S_NS_YELLOW, S_EW_YELLOW: load_value = C_YELLOW_M1;
         S_WALK:                   load_value = C_WALK_M1;
         default:                  load_value = C_ALLRED_M1;
      endcase
   endfunction

   always_ff @(posedge clkin or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_RED2;
         timer_q       <= C_ALLRED_M1;
         ped_pending_q <= 1'b0;
         car_pending_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         timer_q       <= timer_d;
         ped_pending_q <= ped_pending_d;
         car_pending_q <= car_pending_d;
      end
   end

   always_comb begin
      logic expired;
      state_d = state_q;
      timer_d = timer_q;
      expired = bus.tick && (timer_q == 8'd0);
      if (bus.tick && (timer_q != 8'd0)) begin
         timer_d = timer_q - 8'd1;
      end
      if (expired) begin
         case (state_q)
            // Without demand, NS_GREEN parks at timer 0 and retries every tick.
            S_NS_GREEN:  if (car_pending_q || ped_pending_q) state_d = S_NS_YELLOW;
            S_NS_YELLOW: state_d = S_RED1;
            S_RED1:      state_d = ped_pending_q ? S_WALK : S_EW_GREEN;
            S_WALK:      state_d = S_EW_GREEN;
            S_EW_GREEN:  state_d = S_EW_YELLOW;
            S_EW_YELLOW: state_d = S_RED2;
            S_RED2:      state_d = S_NS_GREEN;
            default:     state_d = S_RED2;
         endcase
      end
      if (state_d != state_q) begin
         timer_d = load_value(state_d);
      end

      ped_pending_d = ped_pending_q;
      if (bus.ped_req && (state_q != S_WALK)) ped_pending_d = 1'b1;
      if ((state_d == S_WALK) && (state_q != S_WALK)) ped_pending_d = 1'b0;

      car_pending_d = car_pending_q;
      if (bus.ew_sensor) car_pending_d = 1'b1;
      if ((state_d == S_EW_GREEN) && (state_q != S_EW_GREEN)) car_pending_d = 1'b0;
   end

   always_comb begin
      bus.ns_lamp = C_RED;
      bus.ew_lamp = C_RED;
      bus.walk    = 1'b0;
      bus.phase   = state_q;
      case (state_q)
         S_NS_GREEN:  bus.ns_lamp = C_GREEN;
         S_NS_YELLOW: bus.ns_lamp = C_YELLOW;
         S_EW_GREEN:  bus.ew_lamp = C_GREEN;
         S_EW_YELLOW: bus.ew_lamp = C_YELLOW;
         S_WALK:      bus.walk    = 1'b1;
         default:     bus.walk    = 1'b0;
      endcase
   end

endmodule
`default_nettype wire
